// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares a single-ported, combinational-read data memory between two requesters.
//   Port A: CPU load/store unit, single-word accesses (one-cycle SERVE_A).
//   Port B: debug/DMA loader, auto-incrementing bursts of 1..2^LEN_W-1 beats.
// Arbitration happens only in IDLE with a registered grant. Ties are resolved
// round-robin, and a granted burst runs to completion without preemption.
//
// Build option: define DMEM_ARB_A_PRIO_EN for fixed priority, where port A
// always wins a tie. The default build (macro undefined) is round-robin.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata      port A request and access fields
//   a_gnt/a_rdata                  port A access cycle, read data (0 when idle)
//   b_req/b_we/b_addr/b_len        port B burst request (sampled at grant)
//   b_wdata                        port B write data for the current beat
//   b_gnt/b_rdata/b_done           port B beat strobe, read data, last-beat pulse
//   mem_addr/mem_we/mem_wdata      memory controls (all 0 in IDLE)
//   mem_rdata                      memory combinational read data
module dmem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [LEN_W-1:0]  b_len,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    BURST_B = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            next_state;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  burst_len;
  logic [ADDR_W-1:0] burst_base;
  logic              burst_we;
  logic              last_beat;
  logic              pick_a;

  // burst_len is never 0 once latched, so len-1 cannot underflow
  assign last_beat = (count == (burst_len - LEN_ONE));

`ifdef DMEM_ARB_A_PRIO_EN
  // Fixed priority: port A always wins a tie
  assign pick_a = 1'b1;
`else
  logic last_grant_b;  // 1: port B held the most recent grant

  // Round-robin history; reset to B so that A wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_b <= 1'b1;
    end else if (state == SERVE_A) begin
      last_grant_b <= 1'b0;
    end else if ((state == BURST_B) && last_beat) begin
      last_grant_b <= 1'b1;
    end
  end

  assign pick_a = last_grant_b;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Burst context: latch base/direction/length at grant, step the beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      burst_len  <= '0;
      burst_base <= '0;
      burst_we   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (next_state == BURST_B) begin
            burst_base <= b_addr;
            burst_we   <= b_we;
            burst_len  <= (b_len == '0) ? LEN_ONE : b_len;
            count      <= '0;
          end
        end
        BURST_B: count <= count + LEN_ONE;
        default: count <= count;
      endcase
    end
  end

  // Next-state logic; requests only matter in IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (a_req && b_req) begin
          next_state = pick_a ? SERVE_A : BURST_B;
        end else if (a_req) begin
          next_state = SERVE_A;
        end else if (b_req) begin
          next_state = BURST_B;
        end else begin
          next_state = IDLE;
        end
      end
      SERVE_A: next_state = IDLE;
      BURST_B: begin
        if (last_beat) begin
          next_state = IDLE;
        end else begin
          next_state = BURST_B;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the registered state: reset forces IDLE, so mem_we
  // falls asynchronously with rst even in the middle of a burst
  always_comb begin
    a_gnt     = 1'b0;
    a_rdata   = '0;
    b_gnt     = 1'b0;
    b_rdata   = '0;
    b_done    = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        a_gnt = 1'b0;
      end
      SERVE_A: begin
        a_gnt     = 1'b1;
        a_rdata   = mem_rdata;
        mem_addr  = a_addr;
        mem_we    = a_we;
        mem_wdata = a_wdata;
      end
      BURST_B: begin
        b_gnt     = 1'b1;
        b_rdata   = mem_rdata;
        b_done    = last_beat;
        // modular add: the burst address wraps from the top word back to 0
        mem_addr  = burst_base + {{(ADDR_W-LEN_W){1'b0}}, count};
        mem_we    = burst_we;
        mem_wdata = b_wdata;
      end
      default: begin
        a_gnt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a per-cycle scoreboard. Each scenario pushes
// (stimulus, expected outputs) pairs, then replays them one clock each.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req, a_we, a_gnt;
  logic [13:0] a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_req, b_we, b_gnt, b_done;
  logic [13:0] b_addr;
  logic [4:0]  b_len;
  logic [31:0] b_wdata, b_rdata;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic        mem_clear;

  int n_cmp;
  int n_err;

  typedef struct packed {
    logic        a_req;
    logic        a_we;
    logic [13:0] a_addr;
    logic [31:0] a_wdata;
    logic        b_req;
    logic        b_we;
    logic [13:0] b_addr;
    logic [4:0]  b_len;
    logic [31:0] b_wdata;
  } stim_t;

  typedef struct packed {
    logic        a_gnt;
    logic        b_gnt;
    logic        b_done;
    logic        we;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] a_rdata;
    logic [31:0] b_rdata;
  } exp_t;

  stim_t stim_q [$];
  exp_t  exp_q [$];

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_len     (b_len),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rdata   (b_rdata),
    .b_done    (b_done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write at the rising edge
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic drive(input stim_t s);
    a_req   = s.a_req;
    a_we    = s.a_we;
    a_addr  = s.a_addr;
    a_wdata = s.a_wdata;
    b_req   = s.b_req;
    b_we    = s.b_we;
    b_addr  = s.b_addr;
    b_len   = s.b_len;
    b_wdata = s.b_wdata;
  endtask

  task automatic push(input stim_t s, input exp_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  function automatic exp_t e_idle();
    return '0;
  endfunction

  // Expected port A access cycle; reads return the pre-write memory contents
  function automatic exp_t e_a(input logic we, input logic [13:0] addr, input logic [31:0] wd);
    exp_t e;
    e = {1'b1, 1'b0, 1'b0, we, addr, wd, ref_mem[addr], 32'h0};
    if (we) ref_mem[addr] = wd;
    return e;
  endfunction

  // Expected port B beat
  function automatic exp_t e_b(input logic we, input logic [13:0] addr, input logic [31:0] wd,
                               input logic done);
    exp_t e;
    e = {1'b0, 1'b1, done, we, addr, wd, 32'h0, ref_mem[addr]};
    if (we) ref_mem[addr] = wd;
    return e;
  endfunction

  function automatic exp_t observe();
    return {a_gnt, b_gnt, b_done, mem_we, mem_addr, mem_wdata, a_rdata, b_rdata};
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive('0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t obs;
    @(negedge clk);
    mem_clear = 1'b0;
    obs = observe();
    n_cmp++;
    if (obs !== e_idle()) begin
      n_err++;
      $display("FAIL reset_held: got %h expected %h", obs, e_idle());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    obs = observe();
    n_cmp++;
    if (obs !== e_idle()) begin
      n_err++;
      $display("FAIL reset_release: got %h expected %h", obs, e_idle());
    end
  endtask

  task automatic test_port_a();
    stim_t cur;
    exp_t  obs, e;
    int    cyc;
    cur = '0;
    cur.a_req = 1'b1; cur.a_we = 1'b1; cur.a_addr = 14'd5; cur.a_wdata = 32'hDEADBEEF;
    push(cur, e_idle());
    cur.a_req = 1'b0;
    push(cur, e_a(1'b1, 14'd5, 32'hDEADBEEF));
    cur.a_req = 1'b1; cur.a_we = 1'b0; cur.a_wdata = 32'h0;
    push(cur, e_idle());
    cur.a_req = 1'b0;
    push(cur, e_a(1'b0, 14'd5, 32'h0));
    cur = '0;
    push(cur, e_idle());
    cyc = 0;
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL port_a cyc %0d: got %h expected %h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  task automatic test_burst_wrap();
    stim_t       cur;
    exp_t        obs, e;
    int          cyc;
    logic [13:0] ad;
    // write burst 16382..1, with the request fields changed after grant
    cur = '0;
    cur.b_req = 1'b1; cur.b_we = 1'b1; cur.b_addr = 14'd16382; cur.b_len = 5'd4;
    push(cur, e_idle());
    for (int k = 1; k <= 4; k++) begin
      cur.b_req = 1'b0; cur.b_we = 1'b0; cur.b_addr = 14'h0123; cur.b_len = 5'd7;
      cur.b_wdata = 32'(k);
      ad = 14'd16382 + 14'(k - 1);
      push(cur, e_b(1'b1, ad, 32'(k), (k == 4)));
    end
    cur = '0;
    push(cur, e_idle());
    // read-back burst with noise on the idle port A
    cur.b_req = 1'b1; cur.b_we = 1'b0; cur.b_addr = 14'd16382; cur.b_len = 5'd4;
    push(cur, e_idle());
    for (int k = 1; k <= 4; k++) begin
      cur.b_req = 1'b0;
      cur.a_we = 1'b1; cur.a_addr = 14'h3FFF; cur.a_wdata = 32'hFFFFFFFF;
      ad = 14'd16382 + 14'(k - 1);
      push(cur, e_b(1'b0, ad, 32'h0, (k == 4)));
    end
    cur = '0;
    push(cur, e_idle());
    cyc = 0;
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL burst_wrap cyc %0d: got %h expected %h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  task automatic test_tie();
    stim_t cur;
    exp_t  obs, e;
    int    cyc;
    do_reset();
    cur = '0;
    cur.a_req = 1'b1; cur.a_addr = 14'd5;
    cur.b_req = 1'b1; cur.b_addr = 14'd16383; cur.b_len = 5'd1;
    push(cur, e_idle());
    push(cur, e_a(1'b0, 14'd5, 32'h0));
    push(cur, e_idle());
`ifdef DMEM_ARB_A_PRIO_EN
    push(cur, e_a(1'b0, 14'd5, 32'h0));
    push(cur, e_idle());
    cur.a_req = 1'b0;
    push(cur, e_a(1'b0, 14'd5, 32'h0));
    push(cur, e_idle());
    cur.b_req = 1'b0;
    push(cur, e_b(1'b0, 14'd16383, 32'h0, 1'b1));
    push(cur, e_idle());
`else
    push(cur, e_b(1'b0, 14'd16383, 32'h0, 1'b1));
    push(cur, e_idle());
    cur.a_req = 1'b0; cur.b_req = 1'b0;
    push(cur, e_a(1'b0, 14'd5, 32'h0));
    push(cur, e_idle());
`endif
    cyc = 0;
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL tie_order cyc %0d: got %h expected %h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  task automatic test_no_preempt();
    stim_t cur;
    exp_t  obs, e;
    int    cyc;
    cur = '0;
    cur.b_req = 1'b1; cur.b_we = 1'b1; cur.b_addr = 14'd100; cur.b_len = 5'd31;
    push(cur, e_idle());
    for (int k = 1; k <= 31; k++) begin
      cur.b_req = 1'b0;
      cur.b_wdata = 32'h1000 + 32'(k);
      if (k >= 2) begin
        cur.a_req = 1'b1; cur.a_we = 1'b1; cur.a_addr = 14'd200; cur.a_wdata = 32'hA5A5A5A5;
      end
      push(cur, e_b(1'b1, 14'd100 + 14'(k - 1), 32'h1000 + 32'(k), (k == 31)));
    end
    push(cur, e_idle());
    cur.a_req = 1'b0;
    push(cur, e_a(1'b1, 14'd200, 32'hA5A5A5A5));
    cur = '0;
    push(cur, e_idle());
    cyc = 0;
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL no_preempt cyc %0d: got %h expected %h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  task automatic test_zero_len();
    stim_t cur;
    exp_t  obs, e;
    int    cyc;
    cur = '0;
    cur.b_req = 1'b1; cur.b_we = 1'b1; cur.b_addr = 14'd10; cur.b_len = 5'd0;
    push(cur, e_idle());
    cur.b_req = 1'b0; cur.b_wdata = 32'h00000055;
    push(cur, e_b(1'b1, 14'd10, 32'h00000055, 1'b1));
    cur = '0;
    push(cur, e_idle());
    cur.a_req = 1'b1; cur.a_addr = 14'd10;
    push(cur, e_idle());
    cur.a_req = 1'b0;
    push(cur, e_a(1'b0, 14'd10, 32'h0));
    cur = '0;
    push(cur, e_idle());
    cyc = 0;
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL zero_len cyc %0d: got %h expected %h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  task automatic test_reset_mid();
    stim_t cur;
    exp_t  obs, e;
    int    cyc;
    cur = '0;
    cur.b_req = 1'b1; cur.b_we = 1'b1; cur.b_addr = 14'd300; cur.b_len = 5'd8;
    push(cur, e_idle());
    cur.b_req = 1'b0; cur.b_wdata = 32'h00007701;
    push(cur, e_b(1'b1, 14'd300, 32'h00007701, 1'b0));
    cyc = 0;
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset_mid cyc %0d: got %h expected %h", cyc, obs, e);
      end
      cyc++;
    end
    // beat 2: check it, then assert reset before its closing edge
    @(posedge clk);
    #1;
    b_wdata = 32'h00007702;
    @(negedge clk);
    e = {1'b0, 1'b1, 1'b0, 1'b1, 14'd301, 32'h00007702, 32'h0, ref_mem[301]};
    obs = observe();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_mid beat2: got %h expected %h", obs, e);
    end
    #1;
    rst = 1'b1;
    drive('0);
    #1;
    obs = observe();
    n_cmp++;
    if (obs !== e_idle()) begin
      n_err++;
      $display("FAIL reset_mid async_drop: got %h expected %h", obs, e_idle());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // both request after reset: A first, then read back beats 3..8 unchanged
    cur = '0;
    cur.a_req = 1'b1; cur.a_addr = 14'd300;
    cur.b_req = 1'b1; cur.b_addr = 14'd302; cur.b_len = 5'd6;
    push(cur, e_idle());
    cur.a_req = 1'b0;
    push(cur, e_a(1'b0, 14'd300, 32'h0));
    push(cur, e_idle());
    for (int k = 0; k < 6; k++) begin
      cur.b_req = 1'b0;
      push(cur, e_b(1'b0, 14'd302 + 14'(k), 32'h0, (k == 5)));
    end
    cur = '0;
    push(cur, e_idle());
    cyc = 0;
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset_after cyc %0d: got %h expected %h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    mem_clear = 1'b1;
    drive('0);
    for (int i = 0; i < 16384; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_port_a();
    test_burst_wrap();
    test_tie();
    test_no_preempt();
    test_zero_len();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported 16K-word data memory between two requesters.
  - Port A is the CPU load/store unit: single-word accesses.
  - Port B is the debug/DMA loader: auto-incrementing bursts.
- Sits between both requesters and the data memory.
  - Drives the memory's address, write-enable and write-data inputs.
  - Returns the memory's combinational read data to whichever port holds the grant.
- Round-robin arbitration with a registered grant. A granted burst cannot be preempted.

Parameters:
- ADDR_W, 14, memory word-address width (16384 words).
- DATA_W, 32, data word width.
- LEN_W, 5, width of the burst-length field; maximum burst is 2^LEN_W - 1 = 31 beats.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  port A request; held high until a_gnt is seen.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A access cycle; read data valid and write committed in this cycle.
- a_rdata  out  DATA_W  port A read data; equals mem_rdata while a_gnt=1, else 0.
- b_req  in  1  port B burst request; held high until first b_gnt.
- b_we  in  1  burst direction, sampled at grant.
- b_addr  in  ADDR_W  burst base address, sampled at grant.
- b_len  in  LEN_W  beat count, sampled at grant; 0 is treated as 1.
- b_wdata  in  DATA_W  write data for the current beat.
- b_gnt  out  1  high for every beat of the burst.
- b_rdata  out  DATA_W  read data for the current beat; equals mem_rdata while b_gnt=1, else 0.
- b_done  out  1  one-cycle pulse coincident with the last beat.
- mem_addr  out  ADDR_W  to memory addr.
- mem_we  out  1  to memory MW.
- mem_wdata  out  DATA_W  to memory data_in.
- mem_rdata  in  DATA_W  from memory data_out (combinational read).

Behaviour:
- Reset:
  - state=IDLE, last_grant=B (so port A wins the first tie).
  - Burst counter=0.
  - All outputs 0.
  - Reset is asynchronous: mem_we drops immediately, even mid-burst. The burst is abandoned and not resumed.
- States: IDLE, SERVE_A, BURST_B.
- IDLE:
  - mem_addr, mem_we and mem_wdata are all 0.
  - Requests are sampled at the clock edge.
  - Only a_req=1 -> SERVE_A.
  - Only b_req=1 -> BURST_B; latch b_addr, b_we and len (0 -> 1); count=0.
  - Both requests -> grant the port that is not last_grant.
  - Neither request -> stay in IDLE.
- SERVE_A (exactly 1 cycle):
  - a_gnt=1; mem_* = a_addr / a_we / a_wdata.
  - a_rdata is valid in this cycle; a write is committed at the closing edge.
  - last_grant <= A; next state is IDLE.
- BURST_B (len cycles):
  - b_gnt=1.
  - mem_addr = (base + count) mod 2^ADDR_W; the address wraps from 16383 to 0.
  - mem_we = latched we; mem_wdata = b_wdata.
  - count increments each cycle.
  - On the beat where count == len-1: b_done=1, last_grant <= B, next state is IDLE.
- Latency:
  - Request in cycle N -> grant in cycle N+1.
  - At least one IDLE cycle separates consecutive grants.
- Starvation bound: worst-case wait for port A is 31+2 cycles.
- A request dropped before its grant in IDLE is simply not served.
- Request inputs are ignored outside IDLE. Port A must keep a_req high across a port B burst.
- Inputs to the non-granted port have no effect on mem_*.

Optional Feature:
- Macro: DMEM_ARB_A_PRIO_EN.
- Defined: fixed priority; port A always wins a tie in IDLE and last_grant is unused.
- Undefined: round-robin as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Port A write then read:
  - a_req, we=1, addr=5, wdata=0xDEADBEEF -> a_gnt one cycle later with mem_we=1.
  - Read of addr 5 -> a_gnt and a_rdata=0xDEADBEEF.
- Port B write burst wrap-around:
  - base=16382, len=4, wdata 1..4 -> four b_gnt cycles with mem_addr 16382, 16383, 0, 1.
  - b_done is high on the 4th beat.
  - A read-back burst returns 1..4.
- Tie and round-robin after reset:
  - Both requests held -> grant order A, B, A.
  - With DMEM_ARB_A_PRIO_EN -> grant order A, A, A until a_req drops.
- No preemption:
  - a_req asserted during a 31-beat B burst -> a_gnt only after b_done, plus 2 cycles.
  - mem_addr is never a_addr during the burst.
- Zero length:
  - b_len=0, addr=10 -> one beat at addr 10, with b_done and b_gnt high in the same cycle.
- Reset mid-burst:
  - rst asserted on beat 2 of 8 -> mem_we and b_gnt go to 0 asynchronously.
  - Words at beats 3 to 8 are unchanged.
  - After reset release, state is IDLE and a_req is granted first.
